spi_mem_bridge: RTL and testbench

SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

---
 rtl/spi_mem_bridge.sv | 173 +++++++++++++++++
 tb/tb_spi_mem_bridge.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: SPI-style slave that gives serial access to a small
// synchronous word memory. One clock serves as both bit clock and system clock.
//
// Frame format (SS_n low): 2 command bits, then the payload, MSB first.
//   00 + W bits : load write address
//   01 + W bits : write data word(s); with AUTO_INC, further words follow
//   10 + W bits : load read address
//   11          : read word(s) on MISO; with AUTO_INC, the burst continues
//                 with one dummy MISO=0 cycle between words
// W = max(ADDR_WIDTH, DATA_WIDTH). Raising SS_n aborts any partial word.
//
// Ports:
//   clk   - single clock, all logic on the rising edge
//   rst_n - asynchronous active-low reset (memory contents are kept)
//   SS_n  - slave select, active-low, sampled on clk
//   MOSI  - serial data in, MSB first
//   MISO  - registered serial data out, MSB first; 0 unless shifting read data
module spi_mem_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, PAYLOAD, RD_WAIT, RD_SHIFT, HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [W-1:0]            shreg_q, shreg_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]   rd_buf_q, rd_buf_d;
  logic                    miso_q, miso_d;

  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [W:0]              shift_in;
  logic [W-1:0]            word;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Address post-increment with wrap at the top of the populated range.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (int'(a) >= DEPTH - 1) return '0;
    else                      return a + 1'b1;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  assign MISO = miso_q;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_buf_d  = rd_buf_q;
    miso_d    = 1'b0;
    mem_we    = 1'b0;
    shift_in  = {shreg_q, MOSI};
    word      = shift_in[W-1:0];
    mem_wdata = word[DATA_WIDTH-1:0];

    if (SS_n) begin
      // Deselect wins in every state; partial words are simply dropped.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_d   = {MOSI, 1'b0};
          cnt_d   = '0;
          state_d = CMD;
        end
        CMD: begin
          cmd_d   = {cmd_q[1], MOSI};
          cnt_d   = '0;
          state_d = (cmd_q[1] && MOSI) ? RD_WAIT : PAYLOAD;
        end
        PAYLOAD: begin
          shreg_d = word;
          if (cnt_q == CW'(W - 1)) begin
            cnt_d = '0;
            case (cmd_q)
              2'b00: begin
                wr_addr_d = word[ADDR_WIDTH-1:0];
                state_d   = HOLD;
              end
              2'b10: begin
                rd_addr_d = word[ADDR_WIDTH-1:0];
                state_d   = HOLD;
              end
              2'b01: begin
                // Out-of-range writes are dropped but the address still advances.
                mem_we = in_range(wr_addr_q);
                if (AUTO_INC != 0) wr_addr_d = next_addr(wr_addr_q);
                else               state_d   = HOLD;
              end
              default: state_d = HOLD;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RD_WAIT: begin
          rd_buf_d = in_range(rd_addr_q) ? mem[rd_addr_q] : '0;
          if (AUTO_INC != 0) rd_addr_d = next_addr(rd_addr_q);
          cnt_d   = '0;
          state_d = RD_SHIFT;
        end
        RD_SHIFT: begin
          miso_d   = rd_buf_q[DATA_WIDTH-1];
          rd_buf_d = rd_buf_q << 1;
          cnt_d    = cnt_q + 1'b1;
          // Leaving on the last bit edge makes the next RD_WAIT edge the
          // single dummy cycle of a burst.
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = (AUTO_INC != 0) ? RD_WAIT : HOLD;
          end
        end
        HOLD:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_buf_q  <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_buf_q  <= rd_buf_d;
      miso_q    <= miso_d;
    end
  end

  // Payload shifter is pure data and is always qualified by the counter.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  // Storage survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= mem_wdata;
  end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: directed bench for spi_mem_bridge. Three instances share
// clk/rst_n: dut0 uses defaults, dut1 has DEPTH=200, dut2 has AUTO_INC=0.
// A frame-level model (word array plus address pointers) predicts MISO for
// every cycle; a compare process checks all three MISO outputs each cycle,
// and literal read-back values pin the model.
module tb_spi_mem_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ss_a   [3];
  logic       mosi_a [3];
  logic       exp_a  [3];
  logic       miso0, miso1, miso2;
  logic [2:0] miso_v;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  int mmem   [3][256];
  int mwr    [3];
  int mrd    [3];
  int mdepth [3] = '{256, 200, 256};
  int mainc  [3] = '{1, 1, 0};
  int rdq    [$];
  logic g;

  assign miso_v = {miso2, miso1, miso0};

  always #5 clk = ~clk;

  spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .AUTO_INC(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a[0]), .MOSI(mosi_a[0]), .MISO(miso0));
  spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(200), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a[1]), .MOSI(mosi_a[1]), .MISO(miso1));
  spi_mem_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .AUTO_INC(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a[2]), .MOSI(mosi_a[2]), .MISO(miso2));

  task automatic chk(input string name, input int got, input int exp);
    tot_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic int minc(input int d, input int a);
    return (a >= mdepth[d] - 1) ? 0 : a + 1;
  endfunction

  // Per-cycle MISO comparison against the model's expectation.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 3; d++)
        chk($sformatf("miso_dut%0d_t%0t", d, $time), int'(miso_v[d]), int'(exp_a[d]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // One clock: drive at negedge, expectation applies after the next posedge.
  task automatic step(input int d, input logic ss, input logic b, input logic e,
                      output logic got);
    @(negedge clk);
    ss_a[d]   = ss;
    mosi_a[d] = b;
    exp_a[d]  = e;
    @(posedge clk);
    #1;
    got = miso_v[d];
  endtask

  task automatic send_byte(input int d, input int v);
    logic [7:0] vb;
    logic       x;
    vb = v[7:0];
    for (int i = 7; i >= 0; i--) step(d, 1'b0, vb[i], 1'b0, x);
  endtask

  task automatic end_frame(input int d);
    logic x;
    step(d, 1'b1, 1'b0, 1'b0, x);
  endtask

  task automatic set_addr(input int d, input logic rd, input int a);
    logic x;
    step(d, 1'b0, rd, 1'b0, x);
    step(d, 1'b0, 1'b0, 1'b0, x);
    send_byte(d, a);
    end_frame(d);
    if (rd) mrd[d] = a;
    else    mwr[d] = a;
  endtask

  task automatic write_words(input int d, input int n, input int w0, input int w1,
                             input int w2);
    logic x;
    int   w;
    bit   stop;
    stop = 1'b0;
    step(d, 1'b0, 1'b0, 1'b0, x);
    step(d, 1'b0, 1'b1, 1'b0, x);
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
      send_byte(d, w);
      if (!stop) begin
        if (mwr[d] < mdepth[d]) mmem[d][mwr[d]] = w;
        if (mainc[d] != 0) mwr[d] = minc(d, mwr[d]);
        else               stop = 1'b1;
      end
    end
    end_frame(d);
  endtask

  task automatic read_words(input int d, input int n);
    logic       x;
    logic [7:0] w;
    logic [7:0] cap;
    rdq.delete();
    step(d, 1'b0, 1'b1, 1'b0, x);
    step(d, 1'b0, 1'b1, 1'b0, x);
    for (int k = 0; k < n; k++) begin
      step(d, 1'b0, 1'b0, 1'b0, x);
      w = (mrd[d] < mdepth[d]) ? 8'(mmem[d][mrd[d]]) : 8'h00;
      if (mainc[d] != 0) mrd[d] = minc(d, mrd[d]);
      for (int i = 7; i >= 0; i--) begin
        step(d, 1'b0, 1'b0, w[i], x);
        cap[i] = x;
      end
      rdq.push_back(int'(cap));
    end
    end_frame(d);
  endtask

  initial begin
    logic [7:0] w;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ss_a[d] = 1'b1; mosi_a[d] = 1'b0; exp_a[d] = 1'b0;
      mwr[d] = 0; mrd[d] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_miso", int'(miso_v), 0);
    rst_n = 1'b1;

    // Basic write/read round trip: 0xA5 at 0x05.
    set_addr(0, 1'b0, 'h05);
    write_words(0, 1, 'hA5, 0, 0);
    set_addr(0, 1'b1, 'h05);
    read_words(0, 1);
    chk("basic_read_a5", rdq[0], 'hA5);

    // Burst write/read wrapping through 0xFF -> 0x00.
    set_addr(0, 1'b0, 'hFE);
    write_words(0, 3, 'h11, 'h22, 'h33);
    set_addr(0, 1'b1, 'hFE);
    read_words(0, 3);
    chk("burst_word0", rdq[0], 'h11);
    chk("burst_word1", rdq[1], 'h22);
    chk("burst_word2", rdq[2], 'h33);

    // Aborted write after 5 payload bits leaves memory untouched.
    set_addr(0, 1'b0, 'h10);
    write_words(0, 1, 'h3C, 0, 0);
    set_addr(0, 1'b0, 'h10);
    step(0, 1'b0, 1'b0, 1'b0, g);
    step(0, 1'b0, 1'b1, 1'b0, g);
    w = 8'h77;
    for (int i = 7; i >= 3; i--) step(0, 1'b0, w[i], 1'b0, g);
    end_frame(0);
    set_addr(0, 1'b1, 'h10);
    read_words(0, 1);
    chk("abort_keeps_3c", rdq[0], 'h3C);

    // Reset in the middle of shifting out 0xA5.
    set_addr(0, 1'b1, 'h05);
    step(0, 1'b0, 1'b1, 1'b0, g);
    step(0, 1'b0, 1'b1, 1'b0, g);
    step(0, 1'b0, 1'b0, 1'b0, g);
    w = 8'(mmem[0][5]);
    for (int i = 7; i >= 5; i--) step(0, 1'b0, 1'b0, w[i], g);
    @(negedge clk);
    rst_n     = 1'b0;
    ss_a[0]   = 1'b1;
    exp_a[0]  = 1'b0;
    #1;
    chk("async_reset_miso", int'(miso0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin mwr[d] = 0; mrd[d] = 0; end
    read_words(0, 1);
    chk("post_reset_rd_addr0", rdq[0], 'h33);
    write_words(0, 1, 'h5A, 0, 0);
    set_addr(0, 1'b1, 'h00);
    read_words(0, 1);
    chk("post_reset_wr_addr0", rdq[0], 'h5A);
    set_addr(0, 1'b1, 'h05);
    read_words(0, 1);
    chk("post_reset_mem_kept", rdq[0], 'hA5);

    // DEPTH=200: out-of-range write ignored, burst wraps to 0.
    set_addr(1, 1'b0, 'hC8);
    write_words(1, 1, 'hAB, 0, 0);
    set_addr(1, 1'b1, 'hC8);
    read_words(1, 1);
    chk("depth200_oor_read", rdq[0], 'h00);
    set_addr(1, 1'b0, 'hC7);
    write_words(1, 2, 'h12, 'h34, 0);
    set_addr(1, 1'b1, 'hC7);
    read_words(1, 2);
    chk("depth200_c7", rdq[0], 'h12);
    chk("depth200_wrap", rdq[1], 'h34);
    set_addr(1, 1'b1, 'h00);
    read_words(1, 1);
    chk("depth200_addr0", rdq[0], 'h34);

    // AUTO_INC=0: trailing word is ignored and the write address stays put.
    set_addr(2, 1'b0, 'h21);
    write_words(2, 1, 'h11, 0, 0);
    set_addr(2, 1'b0, 'h20);
    write_words(2, 2, 'h55, 'hAA, 0);
    set_addr(2, 1'b1, 'h20);
    read_words(2, 1);
    chk("noinc_single_write", rdq[0], 'h55);
    write_words(2, 1, 'h66, 0, 0);
    set_addr(2, 1'b1, 'h20);
    read_words(2, 1);
    chk("noinc_wr_addr_kept", rdq[0], 'h66);
    set_addr(2, 1'b1, 'h21);
    read_words(2, 1);
    chk("noinc_neighbor_kept", rdq[0], 'h11);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
